axil_rd_timeout: RTL and testbench

AXIL_RD_TIMEOUT -- requirements
Module: axil_rd_timeout

---
 rtl/axil_rd_timeout_if.sv | 24 ++
 rtl/axil_rd_timeout.sv | 193 +++++++++++++++++++
 tb/tb_axil_rd_timeout.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_rd_timeout_if.sv
// AXI4-Lite read channels (AR + R) bundled for one side of the read timeout guard.
interface axil_rd_timeout_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_rd_timeout.sv
// AXI4-Lite read pass-through with a per-transaction cycle budget; on expiry it answers
// upstream with SLVERR and quietly drains the late downstream beat.
module axil_rd_timeout #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    TIMEOUT    = 16,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = {DATA_WIDTH{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  axil_rd_timeout_if.slave  s_axil,
  axil_rd_timeout_if.master m_axil,
  output logic              timeout_flag,
  input  logic              timeout_clr
);

  localparam int            CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         cnt_inc_s;
  logic                  s_arready_q, s_arready_d;
  logic                  s_rvalid_q, s_rvalid_d;
  logic                  m_arvalid_q, m_arvalid_d;
  logic                  m_rready_q, m_rready_d;
  logic                  flag_q, flag_d;
  logic                  timeout_s;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [2:0]            arprot_q, arprot_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  // Next-state, handshake and budget logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s_arready_d = s_arready_q;
    s_rvalid_d  = s_rvalid_q;
    m_arvalid_d = m_arvalid_q;
    m_rready_d  = m_rready_q;
    araddr_d    = araddr_q;
    arprot_d    = arprot_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    timeout_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_arready_q && s_axil.arvalid) begin
          araddr_d    = s_axil.araddr;
          arprot_d    = s_axil.arprot;
          s_arready_d = 1'b0;
          m_arvalid_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_ADDR;
        end else begin
          s_arready_d = 1'b1;
        end
      end
      ST_ADDR: begin
        if (m_arvalid_q && m_axil.arready) begin
          m_arvalid_d = 1'b0;
          m_rready_d  = 1'b1;
          cnt_d       = cnt_inc_s;
          state_d     = ST_DATA;
        end else if (cnt_q == CNT_MAX) begin
          // arvalid stays up: an issued address may not be retracted
          timeout_s   = 1'b1;
          s_rvalid_d  = 1'b1;
          rdata_d     = ERR_DATA;
          rresp_d     = RESP_SLVERR;
          state_d     = ST_DRAIN;
        end else begin
          cnt_d       = cnt_inc_s;
        end
      end
      ST_DATA: begin
        if (m_rready_q && m_axil.rvalid) begin
          rdata_d     = m_axil.rdata;
          rresp_d     = m_axil.rresp;
          m_rready_d  = 1'b0;
          s_rvalid_d  = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_MAX) begin
          timeout_s   = 1'b1;
          s_rvalid_d  = 1'b1;
          rdata_d     = ERR_DATA;
          rresp_d     = RESP_SLVERR;
          state_d     = ST_DRAIN;
        end else begin
          cnt_d       = cnt_inc_s;
        end
      end
      ST_RESP: begin
        if (s_rvalid_q && s_axil.rready) begin
          s_rvalid_d  = 1'b0;
          s_arready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          s_rvalid_d  = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Pending address first, then swallow the late beat; upstream completes independently.
        if (m_arvalid_q && m_axil.arready) begin
          m_arvalid_d = 1'b0;
          m_rready_d  = 1'b1;
        end else if (m_rready_q && m_axil.rvalid) begin
          m_rready_d  = 1'b0;
        end else begin
          m_rready_d  = m_rready_q;
        end
        if (s_rvalid_q && s_axil.rready) begin
          s_rvalid_d  = 1'b0;
        end else begin
          s_rvalid_d  = s_rvalid_q;
        end
        if (!m_arvalid_d && !m_rready_d && !s_rvalid_d) begin
          s_arready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_DRAIN;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        s_arready_d = 1'b0;
        s_rvalid_d  = 1'b0;
        m_arvalid_d = 1'b0;
        m_rready_d  = 1'b0;
      end
    endcase

    if (timeout_s) begin
      flag_d = 1'b1;
    end else if (timeout_clr) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      s_arready_q <= 1'b0;
      s_rvalid_q  <= 1'b0;
      m_arvalid_q <= 1'b0;
      m_rready_q  <= 1'b0;
      flag_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s_arready_q <= s_arready_d;
      s_rvalid_q  <= s_rvalid_d;
      m_arvalid_q <= m_arvalid_d;
      m_rready_q  <= m_rready_d;
      flag_q      <= flag_d;
    end
  end

  // Address and data payload registers; only meaningful while the matching valid is set.
  always_ff @(posedge clk) begin
    araddr_q <= araddr_d;
    arprot_q <= arprot_d;
    rdata_q  <= rdata_d;
    rresp_q  <= rresp_d;
  end

  assign s_axil.arready = s_arready_q;
  assign s_axil.rvalid  = s_rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;
  assign m_axil.araddr  = araddr_q;
  assign m_axil.arprot  = arprot_q;
  assign m_axil.arvalid = m_arvalid_q;
  assign m_axil.rready  = m_rready_q;
  assign timeout_flag   = flag_q;

endmodule

// File: tb/tb_axil_rd_timeout.sv
// Scoreboard bench for axil_rd_timeout: an upstream master, a configurable downstream
// slave model, and a monitor that pops expected responses on each upstream R handshake.
`timescale 1ns/1ps
module tb_axil_rd_timeout;

  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  typedef struct {
    int          ar_wait;
    int          r_wait;
    bit          no_r;
    logic [31:0] data;
    logic [1:0]  resp;
  } slv_t;

  logic clk;
  logic rst_n;
  logic timeout_flag;
  logic timeout_clr;

  exp_t sb[$];
  slv_t sq[$];

  int checks;
  int failures;
  int cyc;
  int nresp;
  int t_sar, t_arv, t_rv, t_mr, arv_len;
  int bp;
  bit clr_req;
  bit clr_overlap;
  logic [31:0] cur_addr;
  logic [2:0]  cur_prot;

  axil_rd_timeout_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();
  axil_rd_timeout_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();

  axil_rd_timeout #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_axil      (s_if),
    .m_axil      (m_if),
    .timeout_flag(timeout_flag),
    .timeout_clr (timeout_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_ar(input logic [31:0] addr, input logic [2:0] prot);
    int n = 0;
    cur_addr = addr;
    cur_prot = prot;
    s_if.araddr  = addr;
    s_if.arprot  = prot;
    s_if.arvalid = 1'b1;
    while (s_if.arready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("s_ar_accepted", s_if.arready, 1'b1);
    t_sar = cyc;
    @(negedge clk);
    s_if.arvalid = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    int n = 0;
    while (nresp < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("resp_count", nresp, target);
    @(negedge clk);
  endtask

  task automatic clear_flag();
    clr_req = 1'b1;
    repeat (2) @(negedge clk);
    clr_req = 1'b0;
    @(negedge clk);
    check_eq("flag_cleared", timeout_flag, 1'b0);
  endtask

  // Downstream slave model: one config popped per AR seen on the master side.
  initial begin
    slv_t c;
    int   n;
    m_if.arready = 1'b0;
    m_if.rvalid  = 1'b0;
    m_if.rdata   = '0;
    m_if.rresp   = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && m_if.arvalid === 1'b1) begin
        if (sq.size() == 0) begin
          check_eq("m_ar_expected", sq.size(), 1);
          c = '{0, 0, 1'b1, 32'h0, 2'b00};
        end else begin
          c = sq.pop_front();
        end
        repeat (c.ar_wait) @(negedge clk);
        m_if.arready = 1'b1;
        @(negedge clk);
        m_if.arready = 1'b0;
        if (!c.no_r) begin
          repeat (c.r_wait) @(negedge clk);
          m_if.rvalid = 1'b1;
          m_if.rdata  = c.data;
          m_if.rresp  = c.resp;
          n = 0;
          while (m_if.rready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
          end
          check_eq("m_r_accepted", m_if.rready, 1'b1);
          t_mr = cyc;
          @(negedge clk);
          m_if.rvalid = 1'b0;
        end
      end
    end
  end

  // Upstream monitor: timing stamps, stability under backpressure, scoreboard compare.
  initial begin
    bit          prev_arv;
    bit          in_resp;
    logic [31:0] hold_d;
    logic [1:0]  hold_r;
    logic [31:0] arv_addr;
    exp_t        e;
    prev_arv = 1'b0;
    in_resp  = 1'b0;
    s_if.rready = 1'b0;
    timeout_clr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_arv    = 1'b0;
        in_resp     = 1'b0;
        s_if.rready = 1'b0;
        timeout_clr = clr_req;
      end else begin
        if (m_if.arvalid && !prev_arv) begin
          t_arv    = cyc;
          arv_addr = m_if.araddr;
          check_eq("m_araddr", m_if.araddr, cur_addr);
          check_eq("m_arprot", m_if.arprot, cur_prot);
        end else if (m_if.arvalid) begin
          check_eq("m_araddr_stable", m_if.araddr, arv_addr);
        end
        if (!m_if.arvalid && prev_arv) arv_len = cyc - t_arv;
        prev_arv = m_if.arvalid;
        timeout_clr = clr_req || (clr_overlap && (cyc - t_arv == 15));

        if (s_if.rready) begin
          s_if.rready = 1'b0;
          check_eq("s_rvalid_drop", s_if.rvalid, 1'b0);
        end else if (s_if.rvalid) begin
          if (!in_resp) begin
            in_resp = 1'b1;
            t_rv    = cyc;
            hold_d  = s_if.rdata;
            hold_r  = s_if.rresp;
          end else begin
            check_eq("rdata_stable", s_if.rdata, hold_d);
            check_eq("rresp_stable", s_if.rresp, hold_r);
            check_eq("no_ar_in_resp", s_if.arready, 1'b0);
          end
          if (bp > 0) begin
            bp--;
          end else begin
            in_resp     = 1'b0;
            s_if.rready = 1'b1;
            nresp++;
            if (sb.size() == 0) begin
              check_eq("resp_expected", sb.size(), 1);
            end else begin
              e = sb.pop_front();
              check_eq("s_rdata", s_if.rdata, e.data);
              check_eq("s_rresp", s_if.rresp, e.resp);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got cyc=%0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int hi;
    checks = 0; failures = 0; cyc = 0; nresp = 0; bp = 0;
    t_sar = 0; t_arv = 0; t_rv = 0; t_mr = 0; arv_len = 0;
    clr_req = 1'b0; clr_overlap = 1'b0;
    cur_addr = '0; cur_prot = '0;
    s_if.araddr = '0; s_if.arprot = '0; s_if.arvalid = 1'b0;
    rst_n = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_s_arready", s_if.arready, 1'b0);
    check_eq("rst_s_rvalid", s_if.rvalid, 1'b0);
    check_eq("rst_m_arvalid", m_if.arvalid, 1'b0);
    check_eq("rst_m_rready", m_if.rready, 1'b0);
    check_eq("rst_flag", timeout_flag, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("arready_after_reset", s_if.arready, 1'b1);

    // Normal read with downstream waits
    sq.push_back('{2, 3, 1'b0, 32'h1234_5678, 2'b00});
    sb.push_back('{32'h1234_5678, 2'b00});
    do_ar(32'h0000_0100, 3'b010);
    wait_resp(1);
    check_eq("ar_to_m_arvalid", t_arv - t_sar, 1);
    check_eq("m_r_to_s_rvalid", t_rv - t_mr, 1);
    check_eq("flag_normal", timeout_flag, 1'b0);

    // Data timeout, clear coinciding with the timeout, upstream backpressure
    bp = 10;
    clr_overlap = 1'b1;
    sq.push_back('{0, 0, 1'b1, 32'h0, 2'b00});
    sb.push_back('{ERR, 2'b10});
    do_ar(32'h0000_0200, 3'b000);
    wait_resp(2);
    clr_overlap = 1'b0;
    check_eq("data_timeout_latency", t_rv - t_arv, 16);
    check_eq("flag_set_beats_clr", timeout_flag, 1'b1);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_if.arready === 1'b1) hi++;
    end
    check_eq("drain_blocks_ar", hi, 0);
    clear_flag();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Address timeout, arvalid held, late beat drained, next AR only after drain
    sq.push_back('{20, 5, 1'b0, 32'h0000_00AA, 2'b00});
    sb.push_back('{ERR, 2'b10});
    do_ar(32'h0000_0300, 3'b001);
    wait_resp(3);
    check_eq("addr_timeout_latency", t_rv - t_arv, 16);
    sq.push_back('{0, 0, 1'b0, 32'h5555_5555, 2'b00});
    sb.push_back('{32'h5555_5555, 2'b00});
    do_ar(32'h0000_0304, 3'b001);
    check_eq("ar_after_drain", (t_sar > t_mr), 1'b1);
    check_eq("arvalid_held", arv_len, 21);
    wait_resp(4);
    check_eq("flag_addr_timeout", timeout_flag, 1'b1);
    clear_flag();

    // R handshake at the last budget cycle wins
    sq.push_back('{0, 14, 1'b0, 32'hCAFE_F00D, 2'b00});
    sb.push_back('{32'hCAFE_F00D, 2'b00});
    do_ar(32'h0000_0400, 3'b100);
    wait_resp(5);
    check_eq("boundary_latency", t_rv - t_arv, 16);
    check_eq("flag_boundary", timeout_flag, 1'b0);

    // One cycle later is a timeout
    sq.push_back('{0, 15, 1'b0, 32'h0000_BEEF, 2'b01});
    sb.push_back('{ERR, 2'b10});
    do_ar(32'h0000_0500, 3'b000);
    wait_resp(6);
    check_eq("flag_past_boundary", timeout_flag, 1'b1);
    clear_flag();

    // Backpressure on a normal response; rresp passes through unchanged
    bp = 10;
    sq.push_back('{1, 1, 1'b0, 32'h0BAD_CAFE, 2'b01});
    sb.push_back('{32'h0BAD_CAFE, 2'b01});
    do_ar(32'h0000_0600, 3'b011);
    wait_resp(7);

    // Asynchronous reset while waiting for R
    sq.push_back('{0, 0, 1'b1, 32'h0, 2'b00});
    do_ar(32'h0000_0800, 3'b000);
    repeat (3) @(negedge clk);
    check_eq("in_data_before_reset", m_if.rready, 1'b1);
    base = nresp;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_s_arready", s_if.arready, 1'b0);
    check_eq("async_s_rvalid", s_if.rvalid, 1'b0);
    check_eq("async_m_arvalid", m_if.arvalid, 1'b0);
    check_eq("async_m_rready", m_if.rready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("no_resp_after_reset", nresp, base);
    check_eq("idle_after_reset", s_if.arready, 1'b1);

    // Recovery read
    sq.push_back('{0, 0, 1'b0, 32'h600D_F00D, 2'b00});
    sb.push_back('{32'h600D_F00D, 2'b00});
    do_ar(32'h0000_0900, 3'b000);
    wait_resp(base + 1);

    check_eq("sb_empty", sb.size(), 0);
    check_eq("slave_cfg_empty", sq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
